// File: rtl/transmitter.sv
// TX DMA engine: walks length-prefixed frame records in the host TX ring and
// streams their payload into the PHY TX FIFO using the 18-bit flag/byte framing.
module transmitter #(
    parameter int ADDR_W  = 14,
    parameter int MIN_LEN = 14,
    parameter int MAX_LEN = 1518
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic              sys_intr,
    output logic [ADDR_W-2:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [15:0]       mem_dout,
    output logic [17:0]       phy_din,
    output logic              phy_wr_en,
    input  logic              phy_full,
    input  logic              tx_enable,
    input  logic [ADDR_W-2:0] tx_wr_ptr,
    output logic [ADDR_W-2:0] tx_rd_ptr,
    output logic [7:0]        tx_count,
    output logic [7:0]        tx_err_count
);
    localparam int PW = ADDR_W - 1;

    typedef enum logic [2:0] {IDLE, HDR, DATA, EOF, FIN} state_t;
    state_t state;

    logic          armed;
    logic [11:0]   rd_cnt;
    logic          sent;
    logic          vld_p0;
    logic          last_p0;
    logic [11:0]   len_p0;
    logic [PW-1:0] rd_addr;

    logic [11:0]   hdr_len;
    logic          hdr_bad;
    logic [12:0]   len_plus;
    logic [11:0]   nwords;
    logic          start;
    logic          data_rd;
    logic          eof_wr;
    logic [PW-1:0] next_ptr;

    function automatic logic [17:0] fmt_word(input logic [15:0] d, input logic half);
        fmt_word = half ? {2'b10, d[15:8], 8'h00} : {2'b11, d};
    endfunction

    // Header word plus payload rounded up to 8 bytes, expressed in 16-bit words.
    function automatic logic [PW-1:0] record_words(input logic [11:0] len);
        logic [12:0] blocks;
        blocks = ({1'b0, len} + 13'd7) >> 3;
        record_words = PW'({blocks + 13'd1, 2'b00});
    endfunction

    // Read strobe and PHY write are decoded from state so that BRAM data lands
    // exactly one cycle after the strobe and goes straight to the FIFO.
    always_comb begin
        hdr_len   = {mem_dout[3:0], mem_dout[15:8]};
        hdr_bad   = (hdr_len < 12'(MIN_LEN)) || (hdr_len > 12'(MAX_LEN));
        len_plus  = {1'b0, len_p0} + 13'd1;
        nwords    = len_plus[12:1];
        start     = armed && (state == IDLE) && tx_enable && (tx_rd_ptr != tx_wr_ptr);
        data_rd   = (state == DATA) && !phy_full && (rd_cnt < nwords);
        eof_wr    = (state == EOF) && !phy_full;
        next_ptr  = tx_rd_ptr + record_words(len_p0);
        mem_rd_en = start || data_rd;
        mem_addr  = (state == DATA) ? rd_addr : tx_rd_ptr;
        phy_wr_en = vld_p0 || eof_wr;
        phy_din   = vld_p0 ? fmt_word(mem_dout, last_p0 && len_p0[0]) : 18'd0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state        <= IDLE;
            armed        <= 1'b0;
            rd_cnt       <= '0;
            sent         <= 1'b0;
            vld_p0       <= 1'b0;
            last_p0      <= 1'b0;
            sys_intr     <= 1'b0;
            tx_rd_ptr    <= '0;
            tx_count     <= '0;
            tx_err_count <= '0;
        end else begin
            armed    <= 1'b1;
            sys_intr <= 1'b0;
            // p0: BRAM read issued this cycle, data presented to the PHY next cycle
            vld_p0   <= data_rd;
            last_p0  <= data_rd && (rd_cnt == nwords - 12'd1);
            case (state)
                IDLE: begin
                    if (start) state <= HDR;
                end
                HDR: begin
                    rd_cnt <= '0;
                    if (hdr_bad) begin
                        tx_err_count <= tx_err_count + 8'd1;
                        sent         <= 1'b0;
                        state        <= FIN;
                    end else begin
                        sent  <= 1'b1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (data_rd) rd_cnt <= rd_cnt + 12'd1;
                    if (vld_p0 && last_p0) state <= EOF;
                end
                EOF: begin
                    if (!phy_full) state <= FIN;
                end
                FIN: begin
                    tx_rd_ptr <= next_ptr;
                    if (sent) begin
                        tx_count <= tx_count + 8'd1;
                        sys_intr <= tx_enable;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Record length and payload address carry no reset; they are reloaded in HDR.
    always_ff @(posedge sys_clk) begin
        if (state == HDR) begin
            len_p0  <= hdr_len;
            rd_addr <= tx_rd_ptr + PW'(4);
        end else if (data_rd) begin
            rd_addr <= rd_addr + PW'(1);
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for the TX DMA engine: ring BRAM model, expected-word
// scoreboard and a negedge monitor that checks every PHY FIFO write.
module tb_transmitter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        sys_intr;
    logic [12:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_dout;
    logic [17:0] phy_din;
    logic        phy_wr_en;
    logic        phy_full;
    logic        tx_enable;
    logic [12:0] tx_wr_ptr;
    logic [12:0] tx_rd_ptr;
    logic [7:0]  tx_count;
    logic [7:0]  tx_err_count;

    transmitter #(.ADDR_W(14), .MIN_LEN(14), .MAX_LEN(1518)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .sys_intr     (sys_intr),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_dout     (mem_dout),
        .phy_din      (phy_din),
        .phy_wr_en    (phy_wr_en),
        .phy_full     (phy_full),
        .tx_enable    (tx_enable),
        .tx_wr_ptr    (tx_wr_ptr),
        .tx_rd_ptr    (tx_rd_ptr),
        .tx_count     (tx_count),
        .tx_err_count (tx_err_count)
    );

    always #5 sys_clk = ~sys_clk;

    logic [15:0] mem [0:8191];
    always @(posedge sys_clk) begin
        if (mem_rd_en) mem_dout <= mem[mem_addr];
    end

    logic [17:0] exp_q [$];
    logic [17:0] mon_exp;
    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int intr_count = 0;
    int rd_count = 0;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (phy_wr_en) begin
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL phy_write: got %05h while no word was expected", phy_din);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (phy_din !== mon_exp) begin
                        errors++;
                        $display("FAIL phy_din: got %05h expected %05h", phy_din, mon_exp);
                    end
                end
            end
            if (sys_intr) intr_count++;
            if (mem_rd_en) rd_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Writes one record into the ring and queues the PHY words it must produce.
    task automatic put_record(input logic [12:0] wa, input int len, input logic [15:0] seed,
                              output logic [12:0] nxt);
        logic [11:0] l;
        logic [15:0] d;
        int nw;
        l = 12'(len);
        mem[wa] = {l[7:0], 4'h0, l[11:8]};
        for (int r = 1; r < 4; r++) mem[13'(wa + r)] = 16'hA5C3;
        if (len >= 14 && len <= 1518) begin
            nw = (len + 1) / 2;
            for (int i = 0; i < nw; i++) begin
                d = 16'(seed + i * 257);
                mem[13'(wa + 4 + i)] = d;
                if (i == nw - 1 && (len % 2) == 1) exp_q.push_back({2'b10, d[15:8], 8'h00});
                else exp_q.push_back({2'b11, d});
            end
            exp_q.push_back(18'h00000);
        end
        nxt = 13'(wa + 4 + ((len + 7) / 8) * 4);
    endtask

    task automatic wait_ptr(input logic [12:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (tx_rd_ptr !== target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, tx_rd_ptr, target);
    endtask

    logic [12:0] nxt;
    int wr_base;
    int rd_base;
    int n;
    int tc;

    initial begin
        sys_rst   = 1'b0;
        tx_enable = 1'b0;
        phy_full  = 1'b0;
        tx_wr_ptr = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        tick(3);
        check("rst_phy_wr_en", phy_wr_en, 0);
        check("rst_phy_din", phy_din, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_sys_intr", sys_intr, 0);
        check("rst_tx_rd_ptr", tx_rd_ptr, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_tx_err_count", tx_err_count, 0);
        sys_rst = 1'b1;
        tx_enable = 1'b1;
        tick(2);

        // len=60, even payload
        put_record(13'h0000, 60, 16'h1000, nxt);
        tx_wr_ptr = nxt;
        wait_ptr(13'h0024, 400, "t1_rd_ptr");
        tick(4);
        check("t1_tx_count", tx_count, 1);
        check("t1_intr", intr_count, 1);
        check("t1_queue_left", exp_q.size(), 0);

        // len=61, odd tail word
        put_record(13'h0024, 61, 16'h2345, nxt);
        tx_wr_ptr = nxt;
        wait_ptr(13'h0048, 400, "t2_rd_ptr");
        tick(4);
        check("t2_tx_count", tx_count, 2);
        check("t2_intr", intr_count, 2);
        check("t2_queue_left", exp_q.size(), 0);

        // bad lengths: too short then too long
        wr_base = wr_count;
        put_record(13'h0048, 9, 16'h3000, nxt);
        put_record(nxt, 2000, 16'h3100, nxt);
        tx_wr_ptr = nxt;
        wait_ptr(13'h0440, 400, "t4_rd_ptr");
        tick(4);
        check("t4_err_count", tx_err_count, 2);
        check("t4_no_phy_writes", wr_count - wr_base, 0);
        check("t4_tx_count", tx_count, 2);

        // skip forward to the top of the ring with more bad records
        put_record(13'h0440, 4095, 16'h0, nxt);
        put_record(nxt, 4095, 16'h0, nxt);
        put_record(nxt, 4095, 16'h0, nxt);
        put_record(nxt, 1880, 16'h0, nxt);
        tx_wr_ptr = nxt;
        wait_ptr(13'h1FFC, 600, "t4_skip_rd_ptr");
        tick(4);
        check("t4_skip_err_count", tx_err_count, 6);

        // record header at the last ring word, payload wraps to word 0
        put_record(13'h1FFC, 64, 16'h7A01, nxt);
        tx_wr_ptr = nxt;
        wait_ptr(13'h0020, 400, "t3_rd_ptr");
        tick(4);
        check("t3_tx_count", tx_count, 3);
        check("t3_intr", intr_count, 3);
        check("t3_queue_left", exp_q.size(), 0);

        // max-length frame with phy_full toggling every 3 cycles
        put_record(13'h0020, 1518, 16'h0F0F, nxt);
        wr_base = wr_count;
        tx_wr_ptr = nxt;
        n = 0;
        tc = 0;
        while (tx_rd_ptr !== 13'h031C && n < 5000) begin
            tick(1);
            n++;
            tc++;
            if (tc == 3) begin
                phy_full = ~phy_full;
                tc = 0;
            end
        end
        phy_full = 1'b0;
        check("t5_rd_ptr", tx_rd_ptr, 13'h031C);
        tick(4);
        check("t5_phy_writes", wr_count - wr_base, 760);
        check("t5_queue_left", exp_q.size(), 0);
        check("t5_tx_count", tx_count, 4);
        check("t5_intr", intr_count, 4);

        // reset in the middle of a frame
        put_record(13'h031C, 200, 16'h4C4C, nxt);
        wr_base = wr_count;
        tx_wr_ptr = nxt;
        n = 0;
        while (wr_count < wr_base + 10 && n < 200) begin
            tick(1);
            n++;
        end
        check("t6_frame_started", (wr_count - wr_base) >= 10, 1);
        sys_rst = 1'b0;
        #1;
        check("t6_rst_phy_wr_en", phy_wr_en, 0);
        check("t6_rst_phy_din", phy_din, 0);
        check("t6_rst_mem_rd_en", mem_rd_en, 0);
        check("t6_rst_mem_addr", mem_addr, 0);
        check("t6_rst_sys_intr", sys_intr, 0);
        check("t6_rst_tx_rd_ptr", tx_rd_ptr, 0);
        check("t6_rst_tx_count", tx_count, 0);
        check("t6_rst_tx_err_count", tx_err_count, 0);
        exp_q.delete();
        tick(3);
        tx_enable = 1'b0;
        tick(1);
        sys_rst = 1'b1;
        rd_base = rd_count;
        wr_base = wr_count;
        tick(30);
        check("t6_idle_no_reads", rd_count - rd_base, 0);
        check("t6_idle_no_writes", wr_count - wr_base, 0);
        check("t6_idle_rd_ptr", tx_rd_ptr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
